// File: rtl/coreaxitoahbl_read_byte_tracker_pkg.sv
// ---------------------------------------------------------------------------
// coreaxitoahbl_pkg
// Shared definitions for the AXI read byte tracker:
//   - state_e       : tracker FSM states (IDLE, CALC, ACTIVE)
//   - clog2()       : constant ceil(log2()) used to size the lane offset
//   - legal widths  : supported AXI data widths and the widest ARLEN
// ---------------------------------------------------------------------------
package coreaxitoahbl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ACTIVE
    } state_e;

    localparam int unsigned DWIDTH_32     = 32;
    localparam int unsigned DWIDTH_64     = 64;
    localparam int unsigned DWIDTH_128    = 128;
    // AXI4 ARLEN is 8 bits; AXI3 uses 4
    localparam int unsigned MAX_LEN_WIDTH = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rest;
        result = 0;
        if (value > 1) begin
            rest = value - 1;
            while (rest > 0) begin
                result = result + 1;
                rest   = rest >> 1;
            end
        end
        return result;
    endfunction

    function automatic bit legal_dwidth(input int unsigned width);
        return (width == DWIDTH_32) || (width == DWIDTH_64) || (width == DWIDTH_128);
    endfunction

endpackage

// File: rtl/coreaxitoahbl_read_byte_tracker_if.sv
// ---------------------------------------------------------------------------
// coreaxitoahbl_read_byte_tracker_if
// Command and beat-tracking signals of the read byte tracker.
//   master modport : AR decode / R return side (drives command and beats)
//   slave  modport : the tracker itself
// Command : cmdValid, cmdReady, cmdAddrOffset, cmdLen, cmdSize, cmdErr
// Beats   : beatValid, beatLast
// Status  : totalValid, totalBytes, bytesRemain, beatBytes, beatStrb,
//           expectLast, lenErr, strayBeat, busy
// ---------------------------------------------------------------------------
interface coreaxitoahbl_read_byte_tracker_if #(
    parameter int unsigned AXI_DWIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 8
);
    localparam int unsigned BYTES = AXI_DWIDTH / 8;
    localparam int unsigned OFFW  = coreaxitoahbl_pkg::clog2(BYTES);
    localparam int unsigned CNT_W = LEN_WIDTH + OFFW + 1;

    logic                 cmdValid;
    logic                 cmdReady;
    logic [OFFW-1:0]      cmdAddrOffset;
    logic [LEN_WIDTH-1:0] cmdLen;
    logic [2:0]           cmdSize;
    logic                 cmdErr;
    logic                 beatValid;
    logic                 beatLast;
    logic                 totalValid;
    logic [CNT_W-1:0]     totalBytes;
    logic [CNT_W-1:0]     bytesRemain;
    logic [OFFW:0]        beatBytes;
    logic [BYTES-1:0]     beatStrb;
    logic                 expectLast;
    logic                 lenErr;
    logic                 strayBeat;
    logic                 busy;

    modport master (
        output cmdValid, cmdAddrOffset, cmdLen, cmdSize, beatValid, beatLast,
        input  cmdReady, cmdErr, totalValid, totalBytes, bytesRemain,
               beatBytes, beatStrb, expectLast, lenErr, strayBeat, busy
    );

    modport slave (
        input  cmdValid, cmdAddrOffset, cmdLen, cmdSize, beatValid, beatLast,
        output cmdReady, cmdErr, totalValid, totalBytes, bytesRemain,
               beatBytes, beatStrb, expectLast, lenErr, strayBeat, busy
    );

endinterface

// File: rtl/coreaxitoahbl_read_byte_tracker_lane_strb.sv
// ---------------------------------------------------------------------------
// coreaxitoahbl_lane_strb
// Combinational lane decode for one beat of an INCR burst.
//   ptr    in  : current lane pointer (unaligned on the first beat)
//   size   in  : ARSIZE, log2 of bytes per beat
//   first  in  : 1 on the first beat of the burst
//   strb   out : lanes carrying valid data this beat
//   nbytes out : number of valid lanes this beat
// ---------------------------------------------------------------------------
module coreaxitoahbl_lane_strb #(
    parameter int unsigned BYTES = 8,
    parameter int unsigned OFFW  = 3
) (
    input  logic [OFFW-1:0]  ptr,
    input  logic [2:0]       size,
    input  logic             first,
    output logic [BYTES-1:0] strb,
    output logic [OFFW:0]    nbytes
);
    typedef logic [OFFW:0] lane_t;

    lane_t sz;
    lane_t mask;
    lane_t aligned;
    lane_t lo;
    lane_t hi;

    always_comb begin
        sz      = lane_t'(1) << size;
        mask    = sz - lane_t'(1);
        aligned = {1'b0, ptr} & ~mask;
        // only the first beat starts mid-container; later pointers are aligned
        lo      = first ? {1'b0, ptr} : aligned;
        // exclusive upper lane; aligned + sz never exceeds BYTES
        hi      = aligned + sz;
        nbytes  = hi - lo;
        strb    = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            strb[i] = (lane_t'(i) >= lo) && (lane_t'(i) < hi);
        end
    end

endmodule

// File: rtl/coreaxitoahbl_read_byte_tracker.sv
// ---------------------------------------------------------------------------
// coreaxitoahbl_read_byte_tracker
// Accepts one AXI INCR read command, computes the total number of valid
// bytes, then follows the returning R beats giving per-beat byte count,
// lane strobe and bytes remaining, and flags RLAST/length mismatches.
//   ACLK   in : clock, rising edge
//   ARESET in : synchronous active-high reset
//   bus       : slave modport of coreaxitoahbl_read_byte_tracker_if
//               (command, beat handshake and tracking status)
// ---------------------------------------------------------------------------
module coreaxitoahbl_read_byte_tracker #(
    parameter int unsigned AXI_DWIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic ACLK,
    input  logic ARESET,
    coreaxitoahbl_read_byte_tracker_if.slave bus
);
    import coreaxitoahbl_pkg::*;

    localparam int unsigned BYTES  = AXI_DWIDTH / 8;
    localparam int unsigned OFFW   = clog2(BYTES);
    localparam int unsigned CNT_W  = LEN_WIDTH + OFFW + 1;
    // an unsupported build rejects every command instead of mis-tracking
    localparam bit          CFG_OK = legal_dwidth(AXI_DWIDTH) &&
                                     (LEN_WIDTH >= 1) && (LEN_WIDTH <= MAX_LEN_WIDTH);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [OFFW:0]    lane_t;

    state_e               state;
    logic [OFFW-1:0]      off_q;
    logic [OFFW-1:0]      ptr_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] beat_cnt_q;
    logic [2:0]           size_q;
    logic                 first_q;
    logic                 cmd_ready_q;
    logic                 busy_q;
    logic                 total_valid_q;
    logic                 cmd_err_q;
    logic                 len_err_q;
    logic                 stray_q;
    cnt_t                 total_q;
    cnt_t                 remain_q;

    logic [BYTES-1:0]     strb_raw;
    lane_t                bytes_raw;
    lane_t                sz_q;
    lane_t                mask_q;
    lane_t                so_q;
    cnt_t                 total_calc;
    logic [OFFW-1:0]      ptr_next;
    logic                 expect_last;
    logic                 size_ok;

    coreaxitoahbl_lane_strb #(
        .BYTES (BYTES),
        .OFFW  (OFFW)
    ) u_lane_strb (
        .ptr    (ptr_q),
        .size   (size_q),
        .first  (first_q),
        .strb   (strb_raw),
        .nbytes (bytes_raw)
    );

    always_comb begin
        size_ok     = CFG_OK && (32'(bus.cmdSize) <= OFFW);
        sz_q        = lane_t'(1) << size_q;
        mask_q      = sz_q - lane_t'(1);
        so_q        = {1'b0, off_q} & mask_q;
        total_calc  = ((cnt_t'(len_q) + cnt_t'(1)) << size_q) - cnt_t'(so_q);
        // next container start, wrapped modulo BYTES by truncation
        ptr_next    = OFFW'(({1'b0, ptr_q} & ~mask_q) + sz_q);
        expect_last = total_valid_q && (beat_cnt_q == len_q);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= IDLE;
            off_q         <= '0;
            ptr_q         <= '0;
            len_q         <= '0;
            beat_cnt_q    <= '0;
            size_q        <= '0;
            first_q       <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            total_valid_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            stray_q       <= 1'b0;
            total_q       <= '0;
            remain_q      <= '0;
        end else begin
            cmd_err_q <= 1'b0;
            len_err_q <= 1'b0;
            stray_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    stray_q <= bus.beatValid;
                    if (bus.cmdValid && cmd_ready_q) begin
                        state       <= CALC;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        off_q       <= bus.cmdAddrOffset;
                        ptr_q       <= bus.cmdAddrOffset;
                        len_q       <= bus.cmdLen;
                        size_q      <= bus.cmdSize;
                        first_q     <= 1'b1;
                        beat_cnt_q  <= '0;
                        // registered here so the pulse lands in the CALC cycle
                        cmd_err_q   <= !size_ok;
                    end
                end
                CALC: begin
                    stray_q <= bus.beatValid;
                    if (cmd_err_q) begin
                        state       <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        state         <= ACTIVE;
                        total_valid_q <= 1'b1;
                        total_q       <= total_calc;
                        remain_q      <= total_calc;
                    end
                end
                ACTIVE: begin
                    if (bus.beatValid) begin
                        if (bus.beatLast != expect_last) begin
                            len_err_q     <= 1'b1;
                            state         <= IDLE;
                            cmd_ready_q   <= 1'b1;
                            busy_q        <= 1'b0;
                            total_valid_q <= 1'b0;
                            remain_q      <= '0;
                        end else if (expect_last) begin
                            state         <= IDLE;
                            cmd_ready_q   <= 1'b1;
                            busy_q        <= 1'b0;
                            total_valid_q <= 1'b0;
                            remain_q      <= '0;
                        end else begin
                            remain_q   <= remain_q - cnt_t'(bytes_raw);
                            beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
                            ptr_q      <= ptr_next;
                            first_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmdReady    = cmd_ready_q;
    assign bus.cmdErr      = cmd_err_q;
    assign bus.busy        = busy_q;
    assign bus.totalValid  = total_valid_q;
    assign bus.totalBytes  = total_q;
    assign bus.bytesRemain = remain_q;
    assign bus.beatBytes   = total_valid_q ? bytes_raw : '0;
    assign bus.beatStrb    = total_valid_q ? strb_raw : '0;
    assign bus.expectLast  = expect_last;
    assign bus.lenErr      = len_err_q;
    assign bus.strayBeat   = stray_q;

endmodule

// File: tb/tb_coreaxitoahbl_read_byte_tracker.sv
// ---------------------------------------------------------------------------
// tb_coreaxitoahbl_read_byte_tracker
// Drives 64b/AXI4, 32b/AXI3 and 128b/AXI4 instances of the tracker from one
// shared stimulus set; sel picks the instance that sees command and beats.
// ---------------------------------------------------------------------------
module tb_coreaxitoahbl_read_byte_tracker;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    coreaxitoahbl_read_byte_tracker_if #(.AXI_DWIDTH(64),  .LEN_WIDTH(8)) if64 ();
    coreaxitoahbl_read_byte_tracker_if #(.AXI_DWIDTH(32),  .LEN_WIDTH(4)) if32 ();
    coreaxitoahbl_read_byte_tracker_if #(.AXI_DWIDTH(128), .LEN_WIDTH(8)) if128 ();

    coreaxitoahbl_read_byte_tracker #(.AXI_DWIDTH(64), .LEN_WIDTH(8)) u_dut64 (
        .ACLK(ACLK), .ARESET(ARESET), .bus(if64)
    );
    coreaxitoahbl_read_byte_tracker #(.AXI_DWIDTH(32), .LEN_WIDTH(4)) u_dut32 (
        .ACLK(ACLK), .ARESET(ARESET), .bus(if32)
    );
    coreaxitoahbl_read_byte_tracker #(.AXI_DWIDTH(128), .LEN_WIDTH(8)) u_dut128 (
        .ACLK(ACLK), .ARESET(ARESET), .bus(if128)
    );

    int unsigned sel;
    logic        cmd_valid;
    logic [3:0]  cmd_off;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic        beat_valid;
    logic        beat_last;

    assign if64.cmdValid       = cmd_valid && (sel == 0);
    assign if64.cmdAddrOffset  = cmd_off[2:0];
    assign if64.cmdLen         = cmd_len;
    assign if64.cmdSize        = cmd_size;
    assign if64.beatValid      = beat_valid && (sel == 0);
    assign if64.beatLast       = beat_last;

    assign if32.cmdValid       = cmd_valid && (sel == 1);
    assign if32.cmdAddrOffset  = cmd_off[1:0];
    assign if32.cmdLen         = cmd_len[3:0];
    assign if32.cmdSize        = cmd_size;
    assign if32.beatValid      = beat_valid && (sel == 1);
    assign if32.beatLast       = beat_last;

    assign if128.cmdValid      = cmd_valid && (sel == 2);
    assign if128.cmdAddrOffset = cmd_off;
    assign if128.cmdLen        = cmd_len;
    assign if128.cmdSize       = cmd_size;
    assign if128.beatValid     = beat_valid && (sel == 2);
    assign if128.beatLast      = beat_last;

    logic [31:0] o_ready, o_busy, o_tvalid, o_cerr, o_last, o_lerr, o_stray;
    logic [31:0] o_total, o_remain, o_strb, o_bytes;

    always_comb begin
        o_ready  = 32'(if64.cmdReady);
        o_busy   = 32'(if64.busy);
        o_tvalid = 32'(if64.totalValid);
        o_cerr   = 32'(if64.cmdErr);
        o_last   = 32'(if64.expectLast);
        o_lerr   = 32'(if64.lenErr);
        o_stray  = 32'(if64.strayBeat);
        o_total  = 32'(if64.totalBytes);
        o_remain = 32'(if64.bytesRemain);
        o_strb   = 32'(if64.beatStrb);
        o_bytes  = 32'(if64.beatBytes);
        if (sel == 1) begin
            o_ready  = 32'(if32.cmdReady);
            o_busy   = 32'(if32.busy);
            o_tvalid = 32'(if32.totalValid);
            o_cerr   = 32'(if32.cmdErr);
            o_last   = 32'(if32.expectLast);
            o_lerr   = 32'(if32.lenErr);
            o_stray  = 32'(if32.strayBeat);
            o_total  = 32'(if32.totalBytes);
            o_remain = 32'(if32.bytesRemain);
            o_strb   = 32'(if32.beatStrb);
            o_bytes  = 32'(if32.beatBytes);
        end else if (sel == 2) begin
            o_ready  = 32'(if128.cmdReady);
            o_busy   = 32'(if128.busy);
            o_tvalid = 32'(if128.totalValid);
            o_cerr   = 32'(if128.cmdErr);
            o_last   = 32'(if128.expectLast);
            o_lerr   = 32'(if128.lenErr);
            o_stray  = 32'(if128.strayBeat);
            o_total  = 32'(if128.totalBytes);
            o_remain = 32'(if128.bytesRemain);
            o_strb   = 32'(if128.beatStrb);
            o_bytes  = 32'(if128.beatBytes);
        end
    end

    typedef struct {
        logic [31:0] strb;
        logic [31:0] nbytes;
        logic [31:0] last;
        logic [31:0] remain_after;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Push the expected beats of a legal command (address-based model),
    // then present the command and check the CALC and ACTIVE entry.
    task automatic issue(input int unsigned s, input int unsigned off,
                         input int unsigned len, input int unsigned size);
        int unsigned bw, sz, al, start, lo, rem, total;
        beat_t b;
        bw    = (s == 0) ? 8 : (s == 1) ? 4 : 16;
        sz    = 1 << size;
        al    = off & ~(sz - 1);
        total = (len + 1) * sz - (off % sz);
        rem   = total;
        for (int unsigned k = 0; k <= len; k++) begin
            start  = (al + k * sz) % bw;
            lo     = (k == 0) ? off : start;
            b.strb = '0;
            for (int unsigned i = lo; i < start + sz; i++) b.strb[i] = 1'b1;
            b.nbytes       = start + sz - lo;
            rem            = rem - (start + sz - lo);
            b.remain_after = rem;
            b.last         = (k == len) ? 1 : 0;
            sb.push_back(b);
        end
        sel       = s;
        cmd_off   = 4'(off);
        cmd_len   = 8'(len);
        cmd_size  = 3'(size);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("calc_ready",  o_ready,  0);
        check("calc_busy",   o_busy,   1);
        check("calc_tvalid", o_tvalid, 0);
        check("calc_cerr",   o_cerr,   0);
        step();
        check("act_tvalid", o_tvalid, 1);
        check("act_total",  o_total,  total);
        check("act_remain", o_remain, total);
    endtask

    task automatic drain(input int unsigned n);
        beat_t b;
        for (int unsigned k = 0; k < n; k++) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow observed=empty expected=beat");
                return;
            end
            b = sb.pop_front();
            check("beat_strb",  o_strb,  b.strb);
            check("beat_bytes", o_bytes, b.nbytes);
            check("beat_last",  o_last,  b.last);
            beat_valid = 1'b1;
            beat_last  = b.last[0];
            step();
            beat_valid = 1'b0;
            beat_last  = 1'b0;
            check("beat_remain", o_remain, b.remain_after);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"},  o_ready,  1);
        check({tag, "_busy"},   o_busy,   0);
        check({tag, "_tvalid"}, o_tvalid, 0);
        check({tag, "_remain"}, o_remain, 0);
        check({tag, "_strb"},   o_strb,   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        sel        = 0;
        cmd_valid  = 1'b0;
        cmd_off    = '0;
        cmd_len    = '0;
        cmd_size   = '0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        ARESET     = 1'b1;
        repeat (3) step();
        ARESET = 1'b0;
        step();

        // reset state of every instance
        for (int unsigned s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_idle("rst");
            check("rst_total", o_total, 0);
            check("rst_bytes", o_bytes, 0);
            check("rst_cerr",  o_cerr,  0);
            check("rst_lerr",  o_lerr,  0);
            check("rst_stray", o_stray, 0);
            check("rst_last",  o_last,  0);
        end

        // 64b off=3 len=3 size=3: 29 bytes, F8/FF/FF/FF
        issue(0, 3, 3, 3);
        check("t1_total", o_total, 29);
        check("t1_strb0", o_strb, 32'hF8);
        drain(4);
        check_idle("t1_end");

        // 32b AXI3 off=0 len=15 size=2: 64 bytes, no CNT_W overflow at 7 bits
        issue(1, 0, 15, 2);
        check("t2_total", o_total, 64);
        drain(16);
        check_idle("t2_end");

        // 64b narrow off=1 len=3 size=1: 7 bytes, 02/0C/30/C0
        issue(0, 1, 3, 1);
        check("t3_total", o_total, 7);
        check("t3_strb0", o_strb, 32'h02);
        drain(4);
        check_idle("t3_end");

        // 64b size=4 is illegal: cmdErr in CALC, totals untouched
        sel       = 0;
        cmd_off   = 4'd0;
        cmd_len   = 8'd1;
        cmd_size  = 3'd4;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("ill_cerr",  o_cerr,  1);
        check("ill_ready", o_ready, 0);
        step();
        check("ill_cerr_end", o_cerr, 0);
        check_idle("ill");
        check("ill_total_kept", o_total, 7);

        // 128b off=0 len=255 size=4: 4096 bytes
        issue(2, 0, 255, 4);
        check("t4_total", o_total, 4096);
        drain(256);
        check_idle("t4_end");

        // command while busy is ignored
        issue(0, 4, 1, 2);
        cmd_off   = 4'd0;
        cmd_len   = 8'd7;
        cmd_size  = 3'd3;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("busy_ready",  o_ready,  0);
        check("busy_tvalid", o_tvalid, 1);
        check("busy_total",  o_total,  8);
        drain(2);
        check_idle("busy_end");

        // RLAST on beat 2 of 4
        issue(0, 0, 3, 3);
        drain(1);
        check("early_last", o_last, 0);
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        step();
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        check("early_lerr", o_lerr, 1);
        check_idle("early");
        step();
        check("early_lerr_end", o_lerr, 0);
        sb.delete();

        // beat 4 of 4 without RLAST
        issue(0, 0, 3, 3);
        drain(3);
        check("miss_last", o_last, 1);
        beat_valid = 1'b1;
        beat_last  = 1'b0;
        step();
        beat_valid = 1'b0;
        check("miss_lerr", o_lerr, 1);
        check_idle("miss");
        step();
        check("miss_lerr_end", o_lerr, 0);
        sb.delete();

        // reset at beat 2, then a stray beat
        issue(0, 2, 3, 2);
        check("rstm_total", o_total, 14);
        drain(1);
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        check_idle("rstm");
        check("rstm_total0", o_total, 0);
        sb.delete();
        beat_valid = 1'b1;
        step();
        beat_valid = 1'b0;
        check("stray", o_stray, 1);
        check("stray_remain", o_remain, 0);
        check("stray_ready", o_ready, 1);
        step();
        check("stray_end", o_stray, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
